// File: rtl/risc16_mem_ctrl.sv
// Memory and MMIO slave for the risc16 core: big-endian byte RAM, LED register,
// programmable wait states and a one-cycle ready/err completion pulse.
module risc16_mem_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned MEM_BYTES   = 65536,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned LED_W       = 24,
  parameter int unsigned LED_BASE    = 32'h0000_0200,
  parameter              INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oe,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        be,
  input  logic [15:0]       dout,
  output logic [15:0]       din,
  output logic              ready,
  output logic              err,
  output logic [LED_W-1:0]  led
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned     MEM_AW  = (MEM_BYTES > 2) ? $clog2(MEM_BYTES) : 1;
  localparam logic            NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]      CNT_LD  = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LED_LO = ADDR_W'(LED_BASE);
  localparam logic [ADDR_W-1:0] LED_HI = ADDR_W'(LED_BASE + 2);

  if ((MEM_BYTES % 2) != 0 || MEM_BYTES == 0 || 64'(MEM_BYTES) > (64'd1 << ADDR_W)) begin : g_bad_mem
    $error("risc16_mem_ctrl: MEM_BYTES must be even, non-zero and <= 2**ADDR_W");
  end
  if (LED_W < 17 || LED_W > 32) begin : g_bad_led
    $error("risc16_mem_ctrl: LED_W must be in 17..32");
  end
  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("risc16_mem_ctrl: WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_W < 2 || ADDR_W > 32) begin : g_bad_addr
    $error("risc16_mem_ctrl: ADDR_W must be in 2..32");
  end

  logic [7:0]        r_mem [0:MEM_BYTES-1];
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_rd;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_be;
  logic [15:0]       r_dout;
  logic              r_ready;
  logic              r_err;
  logic [15:0]       r_din;
  logic [LED_W-1:0]  r_led;

  logic              w_idle;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_be;
  logic [15:0]       w_dout;
  logic              w_enter_done;
  logic              w_led_lo;
  logic              w_led_hi;
  logic              w_err;
  logic              w_mem_wr;
  logic [MEM_AW-1:0] w_idx_hi;
  logic [MEM_AW-1:0] w_idx_lo;
  logic [15:0]       w_rdata;

  // Completion in the accept cycle (no wait states) must use the live bus, otherwise the latched copy.
  assign w_idle       = (r_state == S_IDLE);
  assign w_rd         = w_idle ? oe   : r_rd;
  assign w_wr         = w_idle ? we   : r_wr;
  assign w_addr       = w_idle ? addr : r_addr;
  assign w_be         = w_idle ? be   : r_be;
  assign w_dout       = w_idle ? dout : r_dout;
  assign w_enter_done = (w_idle && (oe || we) && NO_WAIT) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  assign w_led_lo = (w_addr[ADDR_W-1:1] == LED_LO[ADDR_W-1:1]);
  assign w_led_hi = (w_addr[ADDR_W-1:1] == LED_HI[ADDR_W-1:1]);
  assign w_err    = (w_rd && w_wr) || (!w_led_lo && !w_led_hi && (32'(w_addr) >= MEM_BYTES));
  assign w_mem_wr = w_enter_done && !rst && w_wr && !w_err && !w_led_lo && !w_led_hi;
  assign w_idx_hi = MEM_AW'({w_addr[ADDR_W-1:1], 1'b0});
  assign w_idx_lo = MEM_AW'({w_addr[ADDR_W-1:1], 1'b1});

  // Read data source for the completing access.
  always_comb begin
    w_rdata = 16'h0000;
    if (!w_rd || w_err) begin
      w_rdata = 16'h0000;
    end else if (w_led_lo) begin
      w_rdata = r_led[15:0];
    end else if (w_led_hi) begin
      w_rdata = 16'(r_led[LED_W-1:16]);
    end else begin
      w_rdata = {r_mem[w_idx_hi], r_mem[w_idx_lo]};
    end
  end

  // Access sequencer and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_be    <= 2'b00;
      r_dout  <= 16'h0000;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_din   <= 16'h0000;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_din   <= 16'h0000;
      case (r_state)
        S_IDLE: begin
          if (oe || we) begin
            r_rd    <= oe;
            r_wr    <= we;
            r_addr  <= addr;
            r_be    <= be;
            r_dout  <= dout;
            r_cnt   <= CNT_LD;
            r_state <= NO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_done) begin
        r_ready <= 1'b1;
        r_err   <= w_err;
        r_din   <= w_rdata;
      end
    end
  end

  // LED register; only the low lane of the high word reaches bits above 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= {LED_W{1'b0}};
    end else if (w_enter_done && w_wr && !w_err) begin
      if (w_led_lo && w_be[1]) r_led[15:8] <= w_dout[15:8];
      if (w_led_lo && w_be[0]) r_led[7:0]  <= w_dout[7:0];
      if (w_led_hi && w_be[0]) r_led[LED_W-1:16] <= w_dout[LED_W-17:0];
    end
  end

  // RAM byte lanes: even address holds the high byte.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      if (w_be[1]) r_mem[w_idx_hi] <= w_dout[15:8];
      if (w_be[0]) r_mem[w_idx_lo] <= w_dout[7:0];
    end
  end

  assign din   = r_din;
  assign ready = r_ready;
  assign err   = r_err;
  assign led   = r_led;

endmodule
